uart_cmd_responder: RTL and testbench
=====================================

UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500000, giving the inter-byte timeout in clk cycles (valid range 2..2^24-1).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_data  input  8  head byte of the receive FIFO; show-ahead, valid whenever rx_empty=0.
REQ-005 SHALL have port rx_empty  input  1  receive FIFO empty.
REQ-006 SHALL have port rx_read  output  1  one-cycle pop of the receive FIFO.
REQ-007 SHALL have port tx_data  output  8  byte to push into the transmit FIFO.
REQ-008 SHALL have port tx_write  output  1  one-cycle push strobe for the transmit FIFO.
REQ-009 SHALL have port tx_full  input  1  transmit FIFO full.
REQ-010 SHALL have port ctrl_reg  output  8  live value of register 0.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port err_count  output  8  saturating count of NAK responses sent.

Function
REQ-013 SHALL hold a 16 x 8 register file, addressed by addr[3:0].
REQ-014 SHALL pop one byte only when in a receive state and rx_empty=0: rx_read=1 for one cycle, with rx_data sampled in that same cycle.
REQ-015 SHALL push one byte only when in a send state and tx_full=0: tx_write=1 for one cycle; while tx_full=1 it SHALL stall in that state with tx_write=0.
REQ-016 SHALL use the states IDLE, GET_ADDR, GET_DATA, GET_CHK, EXEC, SEND_ACK, SEND_DATA, SEND_CHK, SEND_NAK.
REQ-017 In IDLE, on popping 0x57 ('W') the block SHALL go to GET_ADDR as a write, and on popping 0x52 ('R') it SHALL go to GET_ADDR as a read.
REQ-018 In IDLE, on popping any other byte the block SHALL go to SEND_NAK.
REQ-019 From GET_ADDR, on a pop, the block SHALL go to GET_DATA (write) or EXEC (read); from GET_DATA, on a pop, it SHALL go to EXEC.
REQ-020 EXEC SHALL last exactly one cycle; the first response tx_write SHALL occur no earlier than the cycle after EXEC.
REQ-021 In EXEC, if addr[7:4]≠0 the block SHALL go to SEND_NAK with no write.
REQ-022 In EXEC for a valid write, the block SHALL update reg[addr] (visible the next cycle) and go to SEND_ACK.
REQ-023 In EXEC for a valid read, the block SHALL latch reg[addr] and go to SEND_ACK.
REQ-024 SEND_ACK SHALL push 0x06, then go to SEND_DATA for a read, or to IDLE for a write.
REQ-025 SEND_DATA SHALL push the latched read byte, then go to IDLE.
REQ-026 SEND_NAK SHALL push 0x15, increment err_count (saturating at 0xFF), then go to IDLE.
REQ-027 The timeout counter SHALL clear on every pop and on entering IDLE.
REQ-028 If the timeout counter reaches TIMEOUT_CYCLES in GET_ADDR, GET_DATA or GET_CHK, the block SHALL return to IDLE silently: no response, no write, no err_count change.
REQ-029 Send states SHALL never time out.
REQ-030 The block SHALL never pop while in a send state or EXEC; receive bytes arriving then SHALL remain queued in the FIFO.
REQ-031 rx_read and tx_write SHALL never both be 1 in the same cycle.

Reset
REQ-032 On reset=0, asynchronously: state=IDLE, all 16 registers=0x00, ctrl_reg=0x00, err_count=0x00, busy=0, rx_read=0, tx_write=0, tx_data=0x00, timeout counter=0.
REQ-033 Reset asserted mid-frame or mid-response SHALL abandon the frame; no partial write SHALL persist.

Configuration
REQ-034 With CMD_CHECKSUM_EN defined, after the last payload byte the block SHALL pass through GET_CHK and pop one checksum byte equal to the XOR of all preceding frame bytes.
REQ-035 With CMD_CHECKSUM_EN defined, a checksum mismatch SHALL cause SEND_NAK with no register write.
REQ-036 With CMD_CHECKSUM_EN defined, read responses SHALL append SEND_CHK, pushing 0x06^data after SEND_DATA.
REQ-037 Without CMD_CHECKSUM_EN, GET_CHK and SEND_CHK SHALL be unreachable and absent from the logic, and frames SHALL carry no checksum byte.

Verification
REQ-038 Write then read: feed 57 03 A5, then 52 03 -> tx bytes 06, 06, A5, and err_count=0.
REQ-039 Register 0: feed 57 00 3C -> ctrl_reg=0x3C starting the cycle after EXEC; tx byte 06.
REQ-040 Bad opcode and bad address: feed 41, then 57 13 FF -> tx bytes 15, 15; err_count=2; all registers unchanged.
REQ-041 Backpressure: hold tx_full=1 for 20 cycles during a read response -> tx_write=0 and rx_read=0 throughout; bytes 06 and data are sent in order after release.
REQ-042 Timeout: with TIMEOUT_CYCLES=16, feed 57 05 then stall 16 cycles, then feed 52 05 -> silent abort; response 06 00.
REQ-043 With CMD_CHECKSUM_EN: 57 02 11 44 (checksum correct) -> 06; 57 02 11 00 -> 15 and reg2 unchanged.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// Byte-command responder: 'W' addr data / 'R' addr frames from an RX FIFO into a 16x8 register file.
// Define CMD_CHECKSUM_EN to add an XOR checksum byte to command frames and read responses.
//   state     | meaning
//   IDLE      | wait for opcode byte
//   GET_ADDR  | wait for address byte
//   GET_DATA  | wait for write data byte
//   GET_CHK   | wait for frame checksum byte (CMD_CHECKSUM_EN only)
//   EXEC      | validate frame, write or read register file
//   SEND_ACK  | push 0x06
//   SEND_DATA | push latched read byte
//   SEND_CHK  | push 0x06 ^ read byte (CMD_CHECKSUM_EN only)
//   SEND_NAK  | push 0x15, bump err_count
module uart_cmd_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       rx_read,
  output logic [7:0] tx_data,
  output logic       tx_write,
  input  logic       tx_full,
  output logic [7:0] ctrl_reg,
  output logic       busy,
  output logic [7:0] err_count
);
  localparam logic [7:0]  OP_WR    = 8'h57;
  localparam logic [7:0]  OP_RD    = 8'h52;
  localparam logic [7:0]  ACK      = 8'h06;
  localparam logic [7:0]  NAK      = 8'h15;
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_DATA, EXEC, SEND_ACK, SEND_DATA, SEND_NAK
`ifdef CMD_CHECKSUM_EN
    , GET_CHK, SEND_CHK
`endif
  } state_t;

  state_t      state;
  state_t      pay_done;
  logic [7:0]  regs [16];
  logic        is_wr;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [7:0]  err_cnt;
  logic [23:0] timer;
  logic        in_rx;
  logic        in_tx;
  logic        rx_ok;
  logic        tx_ok;
  logic        tmo;
  logic [7:0]  tx_byte;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]  chk;
  logic        chk_ok;
`endif

  always_comb begin
    in_rx    = (state == IDLE) || (state == GET_ADDR) || (state == GET_DATA);
    in_tx    = (state == SEND_ACK) || (state == SEND_DATA) || (state == SEND_NAK);
    pay_done = EXEC;
`ifdef CMD_CHECKSUM_EN
    in_rx    = in_rx || (state == GET_CHK);
    in_tx    = in_tx || (state == SEND_CHK);
    pay_done = GET_CHK;
`endif
    case (state)
      SEND_ACK:  tx_byte = ACK;
      SEND_DATA: tx_byte = rdata;
      SEND_NAK:  tx_byte = NAK;
`ifdef CMD_CHECKSUM_EN
      SEND_CHK:  tx_byte = ACK ^ rdata;
`endif
      default:   tx_byte = 8'h00;
    endcase
  end

  // Pop/push strobes are decoded from the current state so a FIFO flag change is honoured the same cycle.
  assign rx_ok     = reset && in_rx && !rx_empty;
  assign tx_ok     = in_tx && !tx_full;
  assign tmo       = (timer == TMO_LAST);
  assign rx_read   = rx_ok;
  assign tx_write  = tx_ok;
  assign tx_data   = tx_byte;
  assign busy      = (state != IDLE);
  assign ctrl_reg  = regs[0];
  assign err_count = err_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      is_wr   <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      rdata   <= '0;
      err_cnt <= '0;
      timer   <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
`ifdef CMD_CHECKSUM_EN
      chk     <= '0;
      chk_ok  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (rx_ok) begin
`ifdef CMD_CHECKSUM_EN
            chk <= rx_data;
`endif
            is_wr <= (rx_data == OP_WR);
            state <= ((rx_data == OP_WR) || (rx_data == OP_RD)) ? GET_ADDR : SEND_NAK;
          end
        end
        GET_ADDR: begin
          if (rx_ok) begin
`ifdef CMD_CHECKSUM_EN
            chk <= chk ^ rx_data;
`endif
            addr  <= rx_data;
            timer <= '0;
            state <= is_wr ? GET_DATA : pay_done;
          end else if (tmo) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        GET_DATA: begin
          if (rx_ok) begin
`ifdef CMD_CHECKSUM_EN
            chk <= chk ^ rx_data;
`endif
            wdata <= rx_data;
            timer <= '0;
            state <= pay_done;
          end else if (tmo) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 24'd1;
          end
        end
`ifdef CMD_CHECKSUM_EN
        GET_CHK: begin
          if (rx_ok) begin
            chk_ok <= (chk == rx_data);
            timer  <= '0;
            state  <= EXEC;
          end else if (tmo) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 24'd1;
          end
        end
`endif
        EXEC: begin
`ifdef CMD_CHECKSUM_EN
          if ((addr[7:4] != 4'h0) || !chk_ok) begin
`else
          if (addr[7:4] != 4'h0) begin
`endif
            state <= SEND_NAK;
          end else begin
            if (is_wr) regs[addr[3:0]] <= wdata;
            else       rdata           <= regs[addr[3:0]];
            state <= SEND_ACK;
          end
        end
        SEND_ACK:  if (tx_ok) state <= is_wr ? IDLE : SEND_DATA;
`ifdef CMD_CHECKSUM_EN
        SEND_DATA: if (tx_ok) state <= SEND_CHK;
        SEND_CHK:  if (tx_ok) state <= IDLE;
`else
        SEND_DATA: if (tx_ok) state <= IDLE;
`endif
        SEND_NAK: begin
          if (tx_ok) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: FIFO models on both sides and a frame-level reference model.
// Follows CMD_CHECKSUM_EN the same way as the design.
module tb_uart_cmd_responder;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       rx_read;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_full = 1'b0;
  logic [7:0] ctrl_reg;
  logic       busy;
  logic [7:0] err_count;

  uart_cmd_responder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty), .rx_read(rx_read),
    .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full), .ctrl_reg(ctrl_reg),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo[$];
  logic [7:0] tx_log[$];
  logic [7:0] exp_q[$];
  logic [7:0] frm[$];
  logic [7:0] m_regs[16];
  int         m_err = 0;
  int         errors = 0;
  int         checks = 0;
  int         overlap = 0;
  int         bp_bad = 0;
  bit         bp_mon = 1'b0;

  // Outputs are read in the active region of the edge, before the design's state update lands.
  always @(posedge clk) begin
    if (rx_read && tx_write) overlap++;
    if (bp_mon && (rx_read || tx_write)) bp_bad++;
    if (rx_read && fifo.size() > 0) void'(fifo.pop_front());
    if (tx_write) tx_log.push_back(tx_data);
    #2;
    rx_empty = (fifo.size() == 0);
    rx_data  = rx_empty ? 8'h00 : fifo[0];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Frame assembly; bad_chk corrupts the trailing checksum when checksums are enabled.
  task automatic build(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d, input bit bad_chk);
    logic [7:0] x;
    frm.delete();
    frm.push_back(op);
    if (op == 8'h57 || op == 8'h52) begin
      frm.push_back(a);
      if (op == 8'h57) frm.push_back(d);
`ifdef CMD_CHECKSUM_EN
      x = 8'h00;
      foreach (frm[i]) x ^= frm[i];
      frm.push_back(bad_chk ? (x ^ 8'h01) : x);
`endif
    end
  endtask

  // Reference: what a frame should do, from the command rules alone.
  task automatic model_frame();
    logic [7:0] op, a, d;
    bit ok;
    op = frm[0];
    if (op != 8'h57 && op != 8'h52) begin
      exp_q.push_back(8'h15);
      if (m_err < 255) m_err++;
      return;
    end
    a = frm[1];
    d = (op == 8'h57) ? frm[2] : 8'h00;
    ok = (a < 8'd16);
`ifdef CMD_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < frm.size() - 1; i++) x ^= frm[i];
      if (x != frm[frm.size()-1]) ok = 1'b0;
    end
`endif
    if (!ok) begin
      exp_q.push_back(8'h15);
      if (m_err < 255) m_err++;
    end else if (op == 8'h57) begin
      m_regs[a[3:0]] = d;
      exp_q.push_back(8'h06);
    end else begin
      exp_q.push_back(8'h06);
      exp_q.push_back(m_regs[a[3:0]]);
`ifdef CMD_CHECKSUM_EN
      exp_q.push_back(8'h06 ^ m_regs[a[3:0]]);
`endif
    end
  endtask

  task automatic load_frame();
    model_frame();
    foreach (frm[i]) fifo.push_back(frm[i]);
  endtask

  task automatic finish_frames(input string tag);
    int n = 0;
    while ((fifo.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " completes"}, int'(n < 500), 1);
    repeat (2) @(negedge clk);
    chk({tag, " tx count"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      chk($sformatf("%s tx byte %0d", tag, i), tx_log[i], exp_q[i]);
    chk({tag, " err_count"}, err_count, m_err);
    chk({tag, " ctrl_reg"}, ctrl_reg, m_regs[0]);
    tx_log.delete();
    exp_q.delete();
  endtask

  task automatic do_frame(input string tag, input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
    build(op, a, d, 1'b0);
    load_frame();
    finish_frames(tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset err_count", err_count, 0);
    chk("reset ctrl_reg", ctrl_reg, 0);
    chk("reset tx_write", tx_write, 0);
    chk("reset rx_read", rx_read, 0);
    chk("reset tx_data", tx_data, 0);
    reset = 1'b1;
    @(negedge clk);

    do_frame("write r3", 8'h57, 8'h03, 8'hA5);
    do_frame("read r3", 8'h52, 8'h03, 8'h00);
    do_frame("write r0", 8'h57, 8'h00, 8'h3C);
    do_frame("bad opcode", 8'h41, 8'h00, 8'h00);
    do_frame("bad address", 8'h57, 8'h13, 8'hFF);
    chk("two naks", err_count, 2);

    // Partial frame then silence: abort lands exactly TMO cycles after the last pop.
    begin
      int n = 0;
      fifo.push_back(8'h57);
      fifo.push_back(8'h05);
      while (fifo.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("timeout frame popped", int'(n < 100), 1);
      repeat (TMO - 1) @(negedge clk);
      chk("timeout not yet", busy, 1);
      @(negedge clk);
      chk("timeout aborted", busy, 0);
      repeat (3) @(negedge clk);
      chk("timeout silent", tx_log.size(), 0);
      chk("timeout err_count", err_count, m_err);
    end
    do_frame("read r5 after timeout", 8'h52, 8'h05, 8'h00);

    // Backpressure: second frame must stay queued while the first response is stalled.
    begin
      int n = 0;
      int len2;
      tx_full = 1'b1;
      build(8'h52, 8'h03, 8'h00, 1'b0);
      load_frame();
      build(8'h52, 8'h00, 8'h00, 1'b0);
      len2 = frm.size();
      load_frame();
      while (fifo.size() != len2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("bp first frame popped", int'(n < 100), 1);
      repeat (2) @(negedge clk);
      bp_mon = 1'b1;
      repeat (20) @(negedge clk);
      bp_mon = 1'b0;
      chk("bp no strobes", bp_bad, 0);
      chk("bp second frame queued", fifo.size(), len2);
      chk("bp nothing sent", tx_log.size(), 0);
      tx_full = 1'b0;
      finish_frames("backpressure");
    end

`ifdef CMD_CHECKSUM_EN
    frm = '{8'h57, 8'h02, 8'h11, 8'h44};
    load_frame();
    finish_frames("chk good write");
    frm = '{8'h57, 8'h02, 8'h22, 8'h00};
    load_frame();
    finish_frames("chk bad write");
    do_frame("chk readback r2", 8'h52, 8'h02, 8'h00);
`endif

    for (int k = 0; k < 30; k++) begin
      int r;
      logic [7:0] op;
      r = $urandom_range(0, 9);
      if (r < 4)      op = 8'h57;
      else if (r < 8) op = 8'h52;
      else begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h57 || op == 8'h52) op = 8'hFF;
      end
      build(op, 8'($urandom_range(0, 19)), 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
      load_frame();
      finish_frames($sformatf("random %0d", k));
    end

    for (int a = 0; a < 16; a++)
      do_frame($sformatf("readback r%0d", a), 8'h52, 8'(a), 8'h00);

    // Reset in the middle of a write frame must leave no trace.
    begin
      int n = 0;
      fifo.push_back(8'h57);
      fifo.push_back(8'h04);
      while (fifo.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      reset = 1'b0;
      fifo.delete();
      tx_log.delete();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_err = 0;
      chk("midframe reset busy", busy, 0);
      chk("midframe reset err_count", err_count, 0);
      reset = 1'b1;
      @(negedge clk);
      do_frame("read r4 after reset", 8'h52, 8'h04, 8'h00);
    end

    chk("rx_read/tx_write overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
